// File: rtl/div_issue_ctrl_pkg.sv
// Shared RISC-V type definitions (riscv_types): ALU op encodings and the
// divider issue-controller state enum.
package riscv_types;

  typedef enum logic [3:0] {
    ALU_DIV  = 4'd0,
    ALU_DIVU = 4'd1,
    ALU_REM  = 4'd2,
    ALU_REMU = 4'd3,
    ALU_ADD  = 4'd4,
    ALU_SUB  = 4'd5,
    ALU_AND  = 4'd6,
    ALU_OR   = 4'd7
  } alu_t;

  typedef enum logic [2:0] {
    DC_IDLE,
    DC_START,
    DC_WAIT,
    DC_WB,
    DC_DRAIN
  } divctl_state_t;

endpackage

// File: rtl/div_issue_ctrl_watchdog.sv
// div_watchdog: saturating cycle counter that flags a hung divider once
// TIMEOUT enabled cycles have elapsed since the last clear.
module div_watchdog #(
  parameter int TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic fire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign fire = enable && (count == LIMIT);

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller for the multi-cycle divider: start/done sequencing, flush
// draining, hazard export and watchdog. Optional result reuse: DIV_REUSE_EN.
module div_issue_ctrl
  import riscv_types::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_valid,
  output logic             i_ready,
  input  alu_t             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [4:0]       i_rd,
  output logic             div_start,
  output alu_t             div_op,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic             pend_valid,
  output logic [4:0]       pend_rd,
  output logic             err_timeout
);

  divctl_state_t state, state_next;
  logic accept;
  logic wd_fire;
  logic timeout_evt;
  logic cache_hit;
  logic [WIDTH-1:0] cache_result;

  assign i_ready   = (state == DC_IDLE) && !flush;
  assign accept    = i_valid && i_ready;
  assign busy      = (state != DC_IDLE);
  assign div_start = (state == DC_START) && !flush;

  // In WAIT a flush outranks the watchdog; in DRAIN flush is irrelevant.
  assign timeout_evt = wd_fire && !div_done &&
                       (((state == DC_WAIT) && !flush) || (state == DC_DRAIN));

  div_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == DC_START),
    .enable ((state == DC_WAIT) || (state == DC_DRAIN)),
    .fire   (wd_fire)
  );

`ifdef DIV_REUSE_EN
  logic             cache_valid;
  alu_t             cache_op;
  logic [WIDTH-1:0] cache_a;
  logic [WIDTH-1:0] cache_b;

  always_ff @(posedge clk) begin
    if (rst || timeout_evt) begin
      cache_valid  <= 1'b0;
      cache_op     <= ALU_DIV;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_result <= '0;
    end else if ((state == DC_WAIT) && div_done && !flush) begin
      cache_valid  <= 1'b1;
      cache_op     <= div_op;
      cache_a      <= div_a;
      cache_b      <= div_b;
      cache_result <= div_result;
    end
  end

  assign cache_hit = cache_valid && (cache_op == i_op) &&
                     (cache_a == i_a) && (cache_b == i_b);
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DC_IDLE: begin
        if (accept) begin
          state_next = cache_hit ? DC_WB : DC_START;
        end
      end
      DC_START: begin
        state_next = flush ? DC_IDLE : DC_WAIT;
      end
      DC_WAIT: begin
        if (flush) begin
          state_next = div_done ? DC_IDLE : DC_DRAIN;
        end else if (div_done) begin
          state_next = DC_WB;
        end else if (wd_fire) begin
          state_next = DC_IDLE;
        end
      end
      DC_WB: begin
        if (wb_ready || flush) begin
          state_next = DC_IDLE;
        end
      end
      DC_DRAIN: begin
        if (div_done || wd_fire) begin
          state_next = DC_IDLE;
        end
      end
      default: state_next = DC_IDLE;
    endcase
  end

  // Operand, writeback and hazard registers follow the same state decisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_op      <= ALU_DIV;
      div_a       <= '0;
      div_b       <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      pend_valid  <= 1'b0;
      pend_rd     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_evt;
      case (state)
        DC_IDLE: begin
          if (accept) begin
            div_op     <= i_op;
            div_a      <= i_a;
            div_b      <= i_b;
            pend_valid <= 1'b1;
            pend_rd    <= i_rd;
            if (cache_hit) begin
              wb_valid <= 1'b1;
              wb_rd    <= i_rd;
              wb_data  <= cache_result;
            end
          end
        end
        DC_START: begin
          if (flush) begin
            pend_valid <= 1'b0;
          end
        end
        DC_WAIT: begin
          if (flush) begin
            pend_valid <= 1'b0;
          end else if (div_done) begin
            wb_valid <= 1'b1;
            wb_rd    <= pend_rd;
            wb_data  <= div_result;
          end else if (wd_fire) begin
            pend_valid <= 1'b0;
          end
        end
        DC_WB: begin
          if (wb_ready || flush) begin
            wb_valid   <= 1'b0;
            pend_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized self-checking bench for div_issue_ctrl; the bench plays the
// divider and predicts each transaction's timing from the protocol rules.
module tb_div_issue_ctrl;
  import riscv_types::*;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst, flush, i_valid, i_ready;
  alu_t             i_op;
  logic [WIDTH-1:0] i_a, i_b;
  logic [4:0]       i_rd;
  logic             div_start;
  alu_t             div_op;
  logic [WIDTH-1:0] div_a, div_b;
  logic             div_done;
  logic [WIDTH-1:0] div_result;
  logic             wb_valid, wb_ready;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             busy, pend_valid;
  logic [4:0]       pend_rd;
  logic             err_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_rd(i_rd),
    .div_start(div_start), .div_op(div_op), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_result(div_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .pend_valid(pend_valid), .pend_rd(pend_rd), .err_timeout(err_timeout)
  );

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // RISC-V M-extension semantics, standing in for the real divider.
  function automatic logic [WIDTH-1:0] ref_div(input alu_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] int_min;
    logic             ovf;
    int_min = {1'b1, {(WIDTH-1){1'b0}}};
    ovf     = (a == int_min) && (b == '1);
    case (op)
      ALU_DIV:  ref_div = (b == 0) ? '1 : ovf ? a : WIDTH'($signed(a) / $signed(b));
      ALU_DIVU: ref_div = (b == 0) ? '1 : a / b;
      ALU_REM:  ref_div = (b == 0) ? a : ovf ? '0 : WIDTH'($signed(a) % $signed(b));
      default:  ref_div = (b == 0) ? a : a % b;
    endcase
  endfunction

  // scen: 0 normal, 1 flush in START, 2 flush in WAIT, 3 flush with done,
  // 4 divider hangs, 5 flush in WB, 6 flush together with wb_ready.
  task automatic apply_stimulus(input alu_t op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [4:0] rd, input int scen, input int done_at,
                                input int flush_at, input int hold);
    logic [WIDTH-1:0] res;
    int               k;
    bit               flushed;
    res = ref_div(op, a, b);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_rd = rd;
    flush = 1'b0; wb_ready = 1'b0; div_done = 1'b0;
    #1 check_output("i_ready_idle", i_ready, 1);
    check_output("busy_idle", busy, 0);
    step();
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_rd = 5'($urandom);
    #1;
    check_output("busy_start", busy, 1);
    check_output("i_ready_start", i_ready, 0);
    check_output("pend_valid_start", pend_valid, 1);
    check_output("pend_rd_start", pend_rd, rd);
    check_output("div_op", div_op, op);
    check_output("div_a", div_a, a);
    check_output("div_b", div_b, b);
    if (scen == 1) begin
      flush = 1'b1;
      #1 check_output("div_start_flushed", div_start, 0);
      step();
      flush = 1'b0;
      #1;
      check_output("busy_after_start_flush", busy, 0);
      check_output("pend_after_start_flush", pend_valid, 0);
      check_output("i_ready_after_start_flush", i_ready, 1);
      check_output("wb_valid_after_start_flush", wb_valid, 0);
      return;
    end
    check_output("div_start", div_start, 1);
    step();
    if (scen == 4) begin
      for (k = 0; k < TIMEOUT; k++) begin
        #1;
        check_output("err_timeout_early", err_timeout, 0);
        check_output("busy_hung", busy, 1);
        check_output("div_start_hung", div_start, 0);
        step();
      end
      check_output("err_timeout_pulse", err_timeout, 1);
      check_output("busy_after_timeout", busy, 0);
      check_output("wb_valid_after_timeout", wb_valid, 0);
      check_output("pend_after_timeout", pend_valid, 0);
      check_output("i_ready_after_timeout", i_ready, 1);
      step();
      check_output("err_timeout_once", err_timeout, 0);
      return;
    end
    k = 0;
    flushed = 1'b0;
    while (1) begin
      div_done   = (k == done_at);
      div_result = div_done ? res : WIDTH'($urandom);
      if (flushed) flush = 1'($urandom_range(0, 1));
      else flush = (scen == 2 && k == flush_at) || (scen == 3 && k == done_at);
      #1;
      check_output("div_start_wait", div_start, 0);
      check_output("i_ready_wait", i_ready, 0);
      check_output("wb_valid_wait", wb_valid, 0);
      check_output("pend_valid_wait", pend_valid, !flushed);
      step();
      if (flush) flushed = 1'b1;
      if (div_done || k > TIMEOUT) break;
      k++;
    end
    div_done = 1'b0;
    flush = 1'b0;
    #1;
    if (scen == 2 || scen == 3) begin
      check_output("busy_after_drain", busy, 0);
      check_output("wb_valid_after_drain", wb_valid, 0);
      check_output("pend_after_drain", pend_valid, 0);
      check_output("i_ready_after_drain", i_ready, 1);
      return;
    end
    check_output("wb_valid", wb_valid, 1);
    check_output("wb_rd", wb_rd, rd);
    check_output("wb_data", wb_data, res);
    check_output("pend_valid_wb", pend_valid, 1);
    for (int h = 0; h < hold; h++) begin
      step();
      check_output("wb_valid_hold", wb_valid, 1);
      check_output("wb_data_hold", wb_data, res);
      check_output("i_ready_hold", i_ready, 0);
    end
    wb_ready = (scen != 5);
    flush    = (scen == 5 || scen == 6);
    step();
    wb_ready = 1'b0;
    flush    = 1'b0;
    #1;
    check_output("wb_valid_after_hs", wb_valid, 0);
    check_output("pend_after_hs", pend_valid, 0);
    check_output("busy_after_hs", busy, 0);
    check_output("i_ready_after_hs", i_ready, 1);
  endtask

  initial begin
    int scen, done_at, flush_at;
    rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_op = ALU_ADD; i_a = '0; i_b = '0; i_rd = '0;
    div_done = 1'b0; div_result = '0; wb_ready = 1'b0;
    step();
    step();
    check_output("rst_busy", busy, 0);
    check_output("rst_wb_valid", wb_valid, 0);
    check_output("rst_wb_data", wb_data, 0);
    check_output("rst_pend_valid", pend_valid, 0);
    check_output("rst_div_op", div_op, ALU_DIV);
    check_output("rst_div_a", div_a, 0);
    check_output("rst_err_timeout", err_timeout, 0);
    rst = 1'b0;

    apply_stimulus(ALU_DIV, 100, 7, 5'd5, 0, 34, 0, 0);
    apply_stimulus(ALU_REM, 100, 7, 5'd6, 0, 10, 0, 10);
    apply_stimulus(ALU_DIVU, 500, 3, 5'd7, 2, 20, 0, 0);
    apply_stimulus(ALU_REMU, 99, 5, 5'd8, 1, 0, 0, 0);
    apply_stimulus(ALU_DIV, 42, 0, 5'd0, 4, 0, 0, 0);
    apply_stimulus(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, 0, 0, 2);
    apply_stimulus(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 3, 5, 0, 0);

`ifdef DIV_REUSE_EN
    apply_stimulus(ALU_DIVU, 32'hFFFF_FFFF, 3, 5'd9, 0, 20, 0, 0);
    i_valid = 1'b1; i_op = ALU_DIVU; i_a = 32'hFFFF_FFFF; i_b = 3; i_rd = 5'd10;
    #1 check_output("reuse_i_ready", i_ready, 1);
    step();
    i_valid = 1'b0;
    #1;
    check_output("reuse_no_start", div_start, 0);
    check_output("reuse_wb_valid", wb_valid, 1);
    check_output("reuse_wb_data", wb_data, 32'h5555_5555);
    check_output("reuse_wb_rd", wb_rd, 10);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    check_output("reuse_wb_done", wb_valid, 0);
`endif

    // Reset while the divider is running.
    i_valid = 1'b1; i_op = ALU_DIV; i_a = 77; i_b = 3; i_rd = 5'd12;
    step();
    i_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_pend", pend_valid, 0);
    check_output("midrst_div_a", div_a, 0);
    check_output("midrst_i_ready", i_ready, 1);

    for (int n = 0; n < 40; n++) begin
      scen     = $urandom_range(0, 6);
      done_at  = $urandom_range(1, WIDTH + 3);
      flush_at = $urandom_range(0, done_at - 1);
      apply_stimulus(alu_t'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0) ? 0 : $urandom,
                     5'($urandom), scen, done_at, flush_at, $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
